// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, sequences branch delay slots through decode stalls,
// and halts after the delay slot of a jump to HALT_ADDRESS or a misaligned redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus8,
  output logic        if_valid,
  output logic        active,
  output logic        fetch_error
);

  typedef enum logic [1:0] {RUN, PENDING, DRAIN, HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pending_target;
  logic        redirect_req;
  logic [31:0] redirect_tgt;

  assign imem_address = pc;

  // A redirect committed this cycle comes either from the live request or from one parked during a stall.
  always_comb begin
    redirect_req = 1'b0;
    redirect_tgt = branch_target;
    if (state == PENDING) begin
      redirect_req = 1'b1;
      redirect_tgt = pending_target;
    end else if (state == RUN) begin
      redirect_req = branch_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pending_target <= 32'h0;
      if_instruction <= 32'h0;
      if_pc          <= 32'h0;
      if_pc_plus8    <= 32'h8;
      if_valid       <= 1'b0;
      active         <= 1'b1;
      fetch_error    <= 1'b0;
    end else begin
      case (state)
        RUN, PENDING: begin
          if (!stall) begin
            // The word fetched this cycle is always delivered, including as a delay slot.
            if_instruction <= imem_instruction;
            if_pc          <= pc;
            if_pc_plus8    <= pc + 32'd8;
            if_valid       <= 1'b1;
            if (redirect_req) begin
              if (redirect_tgt == HALT_ADDRESS) begin
                pc    <= HALT_ADDRESS;
                state <= DRAIN;
              end else if (redirect_tgt[1:0] != 2'b00) begin
                pc          <= pc + 32'd4;
                fetch_error <= 1'b1;
                state       <= DRAIN;
              end else begin
                pc    <= redirect_tgt;
                state <= RUN;
              end
            end else begin
              pc    <= pc + 32'd4;
              state <= RUN;
            end
          end else if (state == RUN && branch_taken) begin
            pending_target <= branch_target;
            state          <= PENDING;
          end
        end
        DRAIN: begin
          if (!stall) begin
            if_valid <= 1'b0;
            active   <= 1'b0;
            state    <= HALTED;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, delay slots, stalls with
// parked redirects, halt on jump-to-zero, misaligned targets and mid-run reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus8;
  logic        if_valid;
  logic        active;
  logic        fetch_error;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_pc_plus8      (if_pc_plus8),
    .if_valid         (if_valid),
    .active           (active),
    .fetch_error      (fetch_error)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: each word is a distinct tag derived from its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  assign imem_instruction = mem_word(imem_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [31:0] exp_pc, input logic exp_valid);
    check({tag, "_pc"}, if_pc, exp_pc);
    check({tag, "_instr"}, if_instruction, mem_word(exp_pc));
    check({tag, "_plus8"}, if_pc_plus8, exp_pc + 32'd8);
    check({tag, "_valid"}, {31'b0, if_valid}, {31'b0, exp_valid});
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    tick();
    reset_n = 1'b1;
    check("rst_addr", imem_address, 32'hBFC00000);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_plus8", if_pc_plus8, 32'h8);
    check("rst_instr", if_instruction, 32'h0);
    check("rst_active", {31'b0, active}, 32'd1);
    check("rst_err", {31'b0, fetch_error}, 32'd0);

    // Sequential fetch, then a branch issued while if_pc = BFC00004
    tick(); check_if("seq0", 32'hBFC00000, 1'b1);
    tick(); check_if("seq1", 32'hBFC00004, 1'b1);
    branch_taken = 1'b1; branch_target = 32'hBFC00100;
    tick(); check_if("dslot", 32'hBFC00008, 1'b1);
    check("br_addr", imem_address, 32'hBFC00100);
    branch_taken = 1'b0;
    tick(); check_if("br_tgt", 32'hBFC00100, 1'b1);

    // Stall for three cycles with a branch in the first one only
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC00200;
    for (int i = 0; i < 3; i++) begin
      tick();
      branch_taken = 1'b0;
      check("stl_pc", if_pc, 32'hBFC00100);
      check("stl_instr", if_instruction, mem_word(32'hBFC00100));
      check("stl_addr", imem_address, 32'hBFC00104);
    end
    stall = 1'b0;
    tick(); check_if("stl_dslot", 32'hBFC00104, 1'b1);
    tick(); check_if("stl_tgt", 32'hBFC00200, 1'b1);

    // Jump to zero: delay slot once, then halted for good
    branch_taken = 1'b1; branch_target = 32'h0;
    tick(); check_if("jz_dslot", 32'hBFC00204, 1'b1);
    check("jz_addr", imem_address, 32'h0);
    check("jz_active", {31'b0, active}, 32'd1);
    branch_taken = 1'b0;
    tick();
    check("halt_valid", {31'b0, if_valid}, 32'd0);
    check("halt_active", {31'b0, active}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'hBFC00300;
    tick(); tick();
    branch_taken = 1'b0;
    check("halt_valid2", {31'b0, if_valid}, 32'd0);
    check("halt_active2", {31'b0, active}, 32'd0);
    check("halt_pc", if_pc, 32'hBFC00204);
    check("halt_addr", imem_address, 32'h0);

    // Misaligned redirect
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    tick(); check_if("ma_seq", 32'hBFC00000, 1'b1);
    branch_taken = 1'b1; branch_target = 32'hBFC00102;
    tick(); check_if("ma_dslot", 32'hBFC00004, 1'b1);
    check("ma_err", {31'b0, fetch_error}, 32'd1);
    check("ma_pc_low", {30'b0, imem_address[1:0]}, 32'd0);
    check("ma_pc_ne", {31'b0, (imem_address == 32'hBFC00102)}, 32'd0);
    branch_taken = 1'b0;
    tick();
    check("ma_active", {31'b0, active}, 32'd0);
    check("ma_valid", {31'b0, if_valid}, 32'd0);
    tick();
    check("ma_err_sticky", {31'b0, fetch_error}, 32'd1);
    check("ma_pc_ne2", {31'b0, (imem_address == 32'hBFC00102)}, 32'd0);

    // Reset while a redirect is parked under stall
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    tick(); check_if("pr_seq", 32'hBFC00000, 1'b1);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC00200;
    tick();
    branch_taken = 1'b0; reset_n = 1'b0;
    tick();
    check("pr_addr", imem_address, 32'hBFC00000);
    check("pr_valid", {31'b0, if_valid}, 32'd0);
    check("pr_err", {31'b0, fetch_error}, 32'd0);
    check("pr_active", {31'b0, active}, 32'd1);
    reset_n = 1'b1; stall = 1'b0;
    tick(); check_if("pr_seq0", 32'hBFC00000, 1'b1);
    tick(); check_if("pr_seq1", 32'hBFC00004, 1'b1);
    check("pr_addr2", imem_address, 32'hBFC00008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the Harvard MIPS core. Sits directly upstream of the byte-addressed, big-endian, combinational-read instruction memory: drives its 32-bit address and captures the returned word.
- Owns the PC and implements MIPS branch-delay-slot sequencing, decode-stage stalls and halt-on-jump-to-zero.
- Produces a registered IF/ID bundle (instruction, PC, PC+8 link value, valid) for decode.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
HALT_ADDRESS, 32'h00000000, redirect target that ends execution after the delay slot

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous reset, active-low; sampled on rising clk
stall  input  1  decode not ready; hold PC and IF/ID outputs
branch_taken  input  1  redirect request for the instruction currently on if_instruction
branch_target  input  32  redirect address, valid when branch_taken=1
imem_address  output  32  byte address to instruction memory (combinational from PC)
imem_instruction  input  32  word returned by instruction memory, same cycle
if_instruction  output  32  registered fetched word
if_pc  output  32  address of if_instruction
if_pc_plus8  output  32  if_pc+8, link value for JAL/JALR/BGEZAL
if_valid  output  1  if_* hold a real instruction
active  output  1  core running; low once halted
fetch_error  output  1  sticky; set on misaligned redirect target

Behaviour:
- imem_address = pc at all times, including while stalled or halted. Memory is combinational, so the word is captured at the same edge.
- Reset (reset_n=0 at a rising edge, from any state, including with stall/branch asserted or a pending redirect):
  - pc=RESET_VECTOR, state=RUN, pending=0.
  - if_instruction=0, if_pc=0, if_pc_plus8=8, if_valid=0, active=1, fetch_error=0.
- States: RUN, PENDING (redirect captured during stall), DRAIN (delay slot fetched, halt follows), HALTED.
- RUN, stall=0:
  - Registers if_instruction<=imem_instruction, if_pc<=pc, if_pc_plus8<=pc+8, if_valid<=1.
  - pc<=pc+4, wrapping modulo 2^32.
  - If branch_taken=1, pc<=branch_target instead. The word fetched this cycle is the delay slot and is always delivered (never squashed).
- RUN, stall=1: pc and all if_* outputs hold.
  - If branch_taken=1, latch branch_target into pending_target and go to PENDING.
  - branch_taken must stay asserted only until decode sees it accepted; fetch ignores further branch_taken while in PENDING.
- PENDING:
  - stall=1: hold everything.
  - stall=0: capture the delay slot as in RUN, set pc<=pending_target, go to RUN.
- Redirect checks, applied when a redirect is committed to pc (RUN or PENDING with stall=0):
  - Target == HALT_ADDRESS: delay slot is still captured, pc<=HALT_ADDRESS, go to DRAIN.
  - Target[1:0] != 0: delay slot is captured, fetch_error<=1, go to DRAIN; pc is not loaded with the misaligned value.
- DRAIN:
  - stall=1: hold.
  - stall=0: if_valid<=0, active<=0, go to HALTED.
  - Result: decode sees the delay slot for exactly one accepted cycle before the halt.
- HALTED: pc, if_instruction, if_pc, if_pc_plus8 frozen; if_valid=0; active=0. Only reset exits.
- Simultaneous stall and branch_taken in RUN: the stall wins, the redirect is remembered (PENDING) and applied on the first non-stalled cycle.
- The redirect check covers only redirect targets. Sequential execution reaching HALT_ADDRESS via pc+4 wrap does not halt.
- No arithmetic overflow flags; all adds are 32-bit modulo.

Test Plan:
- Reset and sequential fetch: reset_n=0 one cycle, preload words at 0xBFC00000/4/8.
  - imem_address=0xBFC00000, if_valid=0 after reset.
  - The next three edges deliver if_pc=0xBFC00000, 0xBFC00004, 0xBFC00008 with matching words; if_pc_plus8=if_pc+8.
- Branch with delay slot: branch_taken=1, target=0xBFC00100 while if_pc=0xBFC00004.
  - Next if_pc=0xBFC00008 (delay slot), then 0xBFC00100.
- Stall with coincident branch: stall=1 for 3 cycles, branch_taken=1 (target 0xBFC00200) in the first cycle only.
  - if_* constant and imem_address constant for 3 cycles.
  - After stall drops: delay slot, then if_pc=0xBFC00200.
- Jump to zero: branch_taken=1, target=0x00000000.
  - Delay-slot word is delivered with if_valid=1 for one cycle.
  - Then if_valid=0 and active=0 permanently; further branch_taken is ignored.
- Misaligned target 0xBFC00102:
  - Delay slot is delivered, fetch_error=1 (sticky), then active=0.
  - pc is never 0xBFC00102.
- Reset mid-operation: assert reset_n=0 while in PENDING with stall=1.
  - Next edge gives pc=0xBFC00000, if_valid=0, fetch_error=0, active=1.
  - The pending target is discarded.
